bit_recorder: RTL

Capture block feeding the serial bit readout/display path: records up to 16 single-bit samples entered by key press (manual) or by a fixed sample tick (timed), packs them into a 16-bit word and reports the index of the last bit written. Its `data` and `last_idx` outputs drive the readout block's `data` and `ji` inputs, which replay bits from `last_idx` down to 0. Sits between the board switches/keys and the readout/7-segment path.

---
 rtl/bit_recorder_pkg.sv | 21 ++
 rtl/bit_recorder_key.sv | 69 ++++++
 rtl/bit_recorder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bit_recorder_pkg.sv
// bit_recorder_pkg: shared state encoding, LED patterns and capacity constants
// for the bit recorder capture block.
package bit_recorder_pkg;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LED_IDLE = 4'b0001;
    localparam logic [3:0] LED_REC  = 4'b0010;
    localparam logic [3:0] LED_FULL = 4'b0100;
    localparam logic [3:0] LED_DONE = 4'b1000;

endpackage

// File: rtl/bit_recorder_key.sv
// key_edge: turns an asynchronous key level into a one-cycle rising-edge pulse.
// 2-flop synchronizer, then (with BIT_RECORDER_DEBOUNCE_EN defined) a filter
// needing DEBOUNCE_CYC identical samples before the level may change.
module key_edge #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    // Two-stage synchronizer for the asynchronous key level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

`ifdef BIT_RECORDER_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DB_W-1:0] db_cnt;
    logic            filt;

    // Filtered level follows the synchronized level only after a full run of
    // DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (sync2 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            filt   <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    logic debounce_unused;
    assign debounce_unused = (DEBOUNCE_CYC != 0);
    assign level = sync2;
`endif

    // Edge register: remembers the previous level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/bit_recorder.sv
// bit_recorder: records up to 16 bits (manual key presses or timed sampling)
// into a packed word for the serial readout path.
// Optional key debounce: define BIT_RECORDER_DEBOUNCE_EN.
module bit_recorder
    import bit_recorder_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 50000,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              key_store,
    input  logic              key_done,
    input  logic              mode,
    output logic [DEPTH-1:0]  data,
    output logic [IDX_W-1:0]  last_idx,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              done,
    output logic [3:0]        led
);

    localparam int unsigned     TICK_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

    logic              store_p;
    logic              done_p;
    logic              bit_s1;
    logic              bit_s2;
    logic              mode_q;
    logic              rec_wr;
    logic [TICK_W-1:0] tick;
    state_t            state;

    key_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_store_key (
        .clk   (clk),
        .rst   (rst),
        .key   (key_store),
        .pulse (store_p)
    );

    key_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_done_key (
        .clk   (clk),
        .rst   (rst),
        .key   (key_done),
        .pulse (done_p)
    );

    // Bit value synchronizer, same depth as the key path so bit and key align
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_s1 <= 1'b0;
            bit_s2 <= 1'b0;
        end else begin
            bit_s1 <= bit_in;
            bit_s2 <= bit_s1;
        end
    end

    // Write request while recording: store key in manual mode, tick wrap in timed mode
    always_comb begin
        rec_wr = 1'b0;
        if (state == REC) begin
            rec_wr = mode_q ? (tick == TICK_LAST) : store_p;
        end
    end

    // Recorder FSM with registered outputs; a write and done_p in the same
    // cycle both take effect, so the final bit is included in the closed record
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data     <= '0;
            last_idx <= '0;
            count    <= '0;
            full     <= 1'b0;
            done     <= 1'b0;
            led      <= LED_IDLE;
            tick     <= '0;
            mode_q   <= 1'b0;
        end else begin
            mode_q <= mode;
            case (state)
                IDLE, DONE: begin
                    tick <= '0;
                    if (store_p) begin
                        data     <= {{(DEPTH-1){1'b0}}, bit_s2};
                        last_idx <= '0;
                        count    <= CNT_W'(1);
                        full     <= 1'b0;
                        done     <= 1'b0;
                        led      <= LED_REC;
                        state    <= REC;
                    end
                end
                REC: begin
                    if (!mode_q || (mode != mode_q) || (tick == TICK_LAST)) begin
                        tick <= '0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                    if (rec_wr) begin
                        data[count[IDX_W-1:0]] <= bit_s2;
                        last_idx               <= count[IDX_W-1:0];
                        count                  <= count + 1'b1;
                    end
                    if (done_p) begin
                        state <= DONE;
                        done  <= 1'b1;
                        led   <= LED_DONE;
                        full  <= rec_wr && (count == CNT_W'(DEPTH - 1));
                    end else if (rec_wr && (count == CNT_W'(DEPTH - 1))) begin
                        state <= FULL;
                        full  <= 1'b1;
                        led   <= LED_FULL;
                    end
                end
                FULL: begin
                    tick <= '0;
                    if (done_p) begin
                        state <= DONE;
                        done  <= 1'b1;
                        led   <= LED_DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    led   <= LED_IDLE;
                end
            endcase
        end
    end

endmodule
